// File: rtl/fsgnj_sched_if.sv
// Handshake/operand bundle between the FP issue ports, fsgnj_sched and the writeback path.
interface fsgnj_sched_if #(
  parameter int unsigned ID_W = 1
);
  logic            req0_valid;
  logic            req0_ready;
  logic [31:0]     req0_rs1;
  logic [31:0]     req0_rs2;
  logic [1:0]      req0_op;
  logic            req1_valid;
  logic            req1_ready;
  logic [31:0]     req1_rs1;
  logic [31:0]     req1_rs2;
  logic [1:0]      req1_op;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_rd;
  logic [ID_W-1:0] out_id;

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_rs1, req0_rs2, req0_op,
    input  req1_valid, req1_rs1, req1_rs2, req1_op,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_rd, out_id
  );

  // Requester/consumer side.
  modport master (
    output req0_valid, req0_rs1, req0_rs2, req0_op,
    output req1_valid, req1_rs1, req1_rs2, req1_op,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_rd, out_id
  );
endinterface

// File: rtl/fsgnj_sched.sv
// Round-robin two-requester scheduler around a single-precision sign-injection datapath.
// Optional FSGNJ_SCHED_PERF_EN adds saturating completion/stall counters.
module fsgnj_sched #(
  parameter int unsigned ID_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  fsgnj_sched_if.slave      bus,
  output logic              busy
`ifdef FSGNJ_SCHED_PERF_EN
  ,
  output logic [15:0]       perf_done,
  output logic [15:0]       perf_stall
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  state_e          state_q;
  logic            last_gnt_q;
  logic [31:0]     rs1_q;
  logic            rs2_sgn_q;
  logic [1:0]      op_q;
  logic            id_q;
  logic            out_valid_q;
  logic [31:0]     out_rd_q;
  logic [ID_W-1:0] out_id_q;

  logic can_accept;
  logic gnt0;
  logic gnt1;
  logic accept;
  logic res_sgn;

  assign can_accept = (state_q == StIdle) || ((state_q == StHold) && bus.out_ready);

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt0 = last_gnt_q;
      gnt1 = ~last_gnt_q;
    end else begin
      gnt0 = bus.req0_valid;
      gnt1 = bus.req1_valid;
    end
  end

  assign bus.req0_ready = gnt0 && can_accept;
  assign bus.req1_ready = gnt1 && can_accept;
  assign accept         = bus.req0_ready || bus.req1_ready;

  always_comb begin
    res_sgn = rs1_q[31];
    case (op_q)
      2'b00:   res_sgn = rs2_sgn_q;
      2'b01:   res_sgn = ~rs2_sgn_q;
      2'b10:   res_sgn = rs1_q[31] ^ rs2_sgn_q;
      default: res_sgn = rs1_q[31];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_gnt_q  <= 1'b1;
      rs1_q       <= '0;
      rs2_sgn_q   <= 1'b0;
      op_q        <= '0;
      id_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_id_q    <= '0;
    end else begin
      if (accept) begin
        rs1_q      <= gnt1 ? bus.req1_rs1 : bus.req0_rs1;
        rs2_sgn_q  <= gnt1 ? bus.req1_rs2[31] : bus.req0_rs2[31];
        op_q       <= gnt1 ? bus.req1_op : bus.req0_op;
        id_q       <= gnt1;
        last_gnt_q <= gnt1;
      end
      case (state_q)
        StIdle: begin
          if (accept) state_q <= StExec;
        end
        StExec: begin
          out_rd_q    <= {res_sgn, rs1_q[30:0]};
          out_id_q    <= ID_W'(id_q);
          out_valid_q <= 1'b1;
          state_q     <= StHold;
        end
        StHold: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= accept ? StExec : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_id    = out_id_q;
  assign busy          = (state_q != StIdle);

`ifdef FSGNJ_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_done  <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid_q && bus.out_ready && (perf_done != 16'hFFFF)) begin
        perf_done <= perf_done + 16'd1;
      end
      if (out_valid_q && !bus.out_ready && (perf_stall != 16'hFFFF)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule
